count_snapshot_fifo: RTL

COUNT_SNAPSHOT_FIFO -- requirements
Module: count_snapshot_fifo

---
 rtl/count_snapshot_fifo.sv | 105 ++++++++++
 1 files changed

// File: rtl/count_snapshot_fifo.sv
// Circular FIFO capturing samples of an upstream 4-bit counter.
// Optional dedup of repeated samples: define CNT_SNAP_DEDUP_EN.
module count_snapshot_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  input  logic       cnt_vld,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] level,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  input  logic       ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] LDEPTH = 5'(DEPTH);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_level;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;

  logic          w_take;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [4:0]    w_level_nxt;

`ifdef CNT_SNAP_DEDUP_EN
  logic [3:0] r_last;
  logic       r_last_vld;

  assign w_take = cnt_vld && !(r_last_vld && cnt_in == r_last);

  // Only samples that actually enter storage become the new reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= 4'h0;
      r_last_vld <= 1'b0;
    end else if (w_push) begin
      r_last     <= cnt_in;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_take = cnt_vld;
`endif

  assign w_pop  = !r_empty && out_ready;
  assign w_push = w_take && (!r_full || w_pop);
  assign w_drop = w_take && r_full && !w_pop;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + 5'd1;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= cnt_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 5'd0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LDEPTH);
      r_empty <= (w_level_nxt == 5'd0);
      // A drop wins over a coincident clear.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign out_valid = !r_empty;
  assign out_data  = r_empty ? 4'h0 : r_mem[r_rptr];
  assign level     = r_level;
  assign full      = r_full;
  assign empty     = r_empty;
  assign overflow  = r_ovf;

endmodule
